upstream_risk_gate: RTL
=======================

UPSTREAM_RISK_GATE -- requirements
Module: upstream_risk_gate

Interface
Parameters:
REQ-001 SHALL provide N_CLIENTS, default 32, number of client entries in the risk table.
REQ-002 SHALL provide ID_W, default 5, client_id width; ID_W >= clog2(N_CLIENTS).
REQ-003 SHALL provide AMT_W, default 16, width of amounts, limits and accumulators.
Ports:
REQ-004 SHALL provide clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL provide HRESETn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL provide req_valid  in  1  request present.
REQ-007 SHALL provide req_ready  out  1  block can accept a request.
REQ-008 SHALL provide req_op  in  2  00 NEW_ORDER, 01 CANCEL, 10 SET_MAX, 11 QUERY.
REQ-009 SHALL provide req_client  in  ID_W  client index.
REQ-010 SHALL provide req_amount  in  AMT_W  order, cancel or new-limit amount (unsigned).
REQ-011 SHALL provide halt  in  1  global kill switch; rejects NEW_ORDER.
REQ-012 SHALL provide resp_valid  out  1  response present.
REQ-013 SHALL provide resp_ready  in  1  consumer takes response.
REQ-014 SHALL provide resp_status  out  2  00 ACCEPT, 01 REJ_LIMIT, 10 REJ_HALT, 11 ERR_ID.
REQ-015 SHALL provide resp_accum  out  AMT_W  client accumulated orders after the operation.
REQ-016 SHALL provide resp_max  out  AMT_W  client max-to-trade after the operation.
REQ-017 SHALL provide reject_count  out  16  saturating count of REJ_LIMIT and REJ_HALT responses.

Function
REQ-018 SHALL hold per-client accum[AMT_W] and max[AMT_W] in an internal register table of N_CLIENTS entries.
REQ-019 SHALL implement FSM IDLE -> READ -> EXEC -> RESP -> IDLE; exactly one state active.
REQ-020 SHALL drive req_ready=1 only in IDLE; handshake on rising edge with req_valid&req_ready, capturing op/client/amount.
REQ-021 SHALL latch the addressed entry in READ and update the table in EXEC; resp_valid rises on the second rising edge after the accepting edge.
REQ-022 SHALL hold resp_valid and all resp_* stable in RESP until resp_ready=1, then return to IDLE; no new request is accepted in that same edge.
REQ-023 SHALL compute NEW_ORDER sum = accum + amount in AMT_W+1 bits; ACCEPT iff sum < {1'b0,max} (strict) and halt=0; on ACCEPT accum <= sum[AMT_W-1:0].
REQ-024 SHALL, for NEW_ORDER with halt=1 in EXEC, return REJ_HALT with no table change; halt takes priority over REJ_LIMIT.
REQ-025 SHALL, for NEW_ORDER failing the limit, return REJ_LIMIT with no table change.
REQ-026 SHALL, for CANCEL, set accum <= accum - amount, floored at 0 when amount > accum; status ACCEPT regardless of halt.
REQ-027 SHALL, for SET_MAX, set max <= amount without touching accum; status ACCEPT regardless of halt; lowering max below accum is legal.
REQ-028 SHALL, for QUERY, leave the table unchanged and return ACCEPT with current values.
REQ-029 SHALL, for req_client >= N_CLIENTS, return ERR_ID, resp_accum=0, resp_max=0, no table change, no reject_count increment.
REQ-030 SHALL increment reject_count by 1 in EXEC on REJ_LIMIT or REJ_HALT, saturating at 16'hFFFF.
REQ-031 SHALL never write more than one table entry per cycle; the sole writer is EXEC.

Reset
REQ-032 SHALL, on HRESETn=0 at any time, immediately force FSM to IDLE, resp_valid=0, resp_status=0, resp_accum=0, resp_max=0, reject_count=0, and all accum and max entries to 0.
REQ-033 SHALL hold req_ready=0 while HRESETn=0 and drive req_ready=1 from the first edge after release.
REQ-034 SHALL discard an in-flight request when reset asserts mid-operation, with no response ever issued for it.
REQ-035 SHALL, after reset, return REJ_LIMIT for any NEW_ORDER with amount >= 0 until SET_MAX is applied, since max=0.

Verification
REQ-036 SHALL cover SET_MAX c3 amt 100; NEW_ORDER c3 60 -> ACCEPT accum 60; NEW_ORDER c3 40 -> REJ_LIMIT accum 60 (100 not < 100); NEW_ORDER c3 39 -> ACCEPT accum 99.
REQ-037 SHALL cover CANCEL c3 200 with accum 99 -> ACCEPT accum 0; QUERY c3 -> ACCEPT accum 0 max 100.
REQ-038 SHALL cover halt=1, NEW_ORDER c0 1 with max 50 -> REJ_HALT, reject_count+1; SET_MAX c0 10 under halt -> ACCEPT max 10.
REQ-039 SHALL cover N_CLIENTS=20, ID_W=5: NEW_ORDER c25 -> ERR_ID, table and reject_count unchanged.
REQ-040 SHALL cover resp_ready held 0 for 5 cycles -> resp_* stable, req_ready=0; and HRESETn pulse in EXEC -> no response, all table entries 0.
REQ-041 SHALL cover AMT_W=16: max 16'hFFFF, accum 16'hFFF0, NEW_ORDER 16'h0020 -> REJ_LIMIT with no wrap; assertions on one-hot FSM and resp_valid only in RESP throughout.

Source files
------------

// File: rtl/upstream_risk_gate.sv
// upstream_risk_gate
//   Pre-trade risk gate. Holds a per-client table of accumulated order volume
//   and a max-to-trade limit. Each request is accepted, then the addressed
//   entry is read, updated and answered, one request at a time.
//
// Ports
//   clk           single clock, all state on the rising edge
//   HRESETn       asynchronous active-low reset
//   req_valid     request present
//   req_ready     block can accept a request (IDLE only, low while in reset)
//   req_op        00 NEW_ORDER, 01 CANCEL, 10 SET_MAX, 11 QUERY
//   req_client    client index
//   req_amount    order / cancel / new-limit amount (unsigned)
//   halt          global kill switch, rejects NEW_ORDER
//   resp_valid    response present (RESP only)
//   resp_ready    consumer takes the response
//   resp_status   00 ACCEPT, 01 REJ_LIMIT, 10 REJ_HALT, 11 ERR_ID
//   resp_accum    client accumulated orders after the operation
//   resp_max      client max-to-trade after the operation
//   reject_count  saturating count of REJ_LIMIT and REJ_HALT responses
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for req_valid; req_ready high
// READ  | addressed table entry latched into the working registers
// EXEC  | decision made, table entry and response registers updated
// RESP  | response held until resp_ready

module upstream_risk_gate #(
  parameter int N_CLIENTS = 32,
  parameter int ID_W      = 5,
  parameter int AMT_W     = 16
) (
  input  logic             clk,
  input  logic             HRESETn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [ID_W-1:0]  req_client,
  input  logic [AMT_W-1:0] req_amount,
  input  logic             halt,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [1:0]       resp_status,
  output logic [AMT_W-1:0] resp_accum,
  output logic [AMT_W-1:0] resp_max,
  output logic [15:0]      reject_count
);

  // One-hot encoding keeps the state decode trivial and makes an illegal
  // multi-hot state easy to spot.
  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_READ = 4'b0010;
  localparam logic [3:0] ST_EXEC = 4'b0100;
  localparam logic [3:0] ST_RESP = 4'b1000;

  localparam logic [1:0] OP_NEW    = 2'b00;
  localparam logic [1:0] OP_CANCEL = 2'b01;
  localparam logic [1:0] OP_SETMAX = 2'b10;
  localparam logic [1:0] OP_QUERY  = 2'b11;

  localparam logic [1:0] RS_ACCEPT = 2'b00;
  localparam logic [1:0] RS_LIMIT  = 2'b01;
  localparam logic [1:0] RS_HALT   = 2'b10;
  localparam logic [1:0] RS_ERR_ID = 2'b11;

  logic [3:0]       state;
  logic [3:0]       state_nxt;
  logic             live;
  logic             accept;
  logic             id_ok_in;

  logic [1:0]       op_q;
  logic [ID_W-1:0]  client_q;
  logic [AMT_W-1:0] amount_q;
  logic             id_ok_q;
  logic [AMT_W-1:0] cur_accum;
  logic [AMT_W-1:0] cur_max;

  logic [AMT_W-1:0] accum_tbl [N_CLIENTS];
  logic [AMT_W-1:0] max_tbl   [N_CLIENTS];

  logic [AMT_W:0]   sum;
  logic [1:0]       exec_status;
  logic [AMT_W-1:0] new_accum;
  logic [AMT_W-1:0] new_max;
  logic             wr_en;
  logic             count_rej;

  // live holds req_ready low through reset and the edge that releases it.
  assign req_ready  = live && (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign accept     = req_valid && req_ready;
  // Compare in 32 bits so N_CLIENTS == 2**ID_W does not wrap to zero.
  assign id_ok_in   = (32'(req_client) < N_CLIENTS);

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      live <= 1'b0;
    end else begin
      live <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_READ;
      ST_READ: state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      op_q     <= OP_NEW;
      client_q <= '0;
      amount_q <= '0;
      id_ok_q  <= 1'b0;
    end else if (accept) begin
      op_q     <= req_op;
      client_q <= req_client;
      amount_q <= req_amount;
      id_ok_q  <= id_ok_in;
    end
  end

  // Out-of-range clients never index the table; they read back as zero.
  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      cur_accum <= '0;
      cur_max   <= '0;
    end else if (state == ST_READ) begin
      if (id_ok_q) begin
        cur_accum <= accum_tbl[client_q];
        cur_max   <= max_tbl[client_q];
      end else begin
        cur_accum <= '0;
        cur_max   <= '0;
      end
    end
  end

  // One extra bit so a large order cannot wrap and slip under the limit.
  assign sum = {1'b0, cur_accum} + {1'b0, amount_q};

  always_comb begin
    exec_status = RS_ACCEPT;
    new_accum   = cur_accum;
    new_max     = cur_max;
    wr_en       = 1'b0;
    count_rej   = 1'b0;
    if (!id_ok_q) begin
      exec_status = RS_ERR_ID;
      new_accum   = '0;
      new_max     = '0;
    end else begin
      case (op_q)
        OP_NEW: begin
          if (halt) begin
            exec_status = RS_HALT;
            count_rej   = 1'b1;
          end else if (sum < {1'b0, cur_max}) begin
            new_accum = sum[AMT_W-1:0];
            wr_en     = 1'b1;
          end else begin
            exec_status = RS_LIMIT;
            count_rej   = 1'b1;
          end
        end
        OP_CANCEL: begin
          new_accum = (amount_q > cur_accum) ? '0 : (cur_accum - amount_q);
          wr_en     = 1'b1;
        end
        OP_SETMAX: begin
          new_max = amount_q;
          wr_en   = 1'b1;
        end
        OP_QUERY: begin
          wr_en = 1'b0;
        end
        default: begin
          wr_en = 1'b0;
        end
      endcase
    end
  end

  // Sole table writer: one entry, EXEC only.
  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < N_CLIENTS; i++) begin
        accum_tbl[i] <= '0;
        max_tbl[i]   <= '0;
      end
    end else if ((state == ST_EXEC) && wr_en) begin
      accum_tbl[client_q] <= new_accum;
      max_tbl[client_q]   <= new_max;
    end
  end

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      resp_status <= RS_ACCEPT;
      resp_accum  <= '0;
      resp_max    <= '0;
    end else if (state == ST_EXEC) begin
      resp_status <= exec_status;
      resp_accum  <= new_accum;
      resp_max    <= new_max;
    end
  end

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      reject_count <= '0;
    end else if ((state == ST_EXEC) && count_rej && (reject_count != 16'hFFFF)) begin
      reject_count <= reject_count + 16'd1;
    end
  end

endmodule
